// File: rtl/packed_reg_arbiter.sv
// packed_reg_arbiter: two-requester round-robin arbiter writing bit/byte/half/word fields of a 32-bit register
module packed_reg_arbiter #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req0_op,
  input  logic [1:0]  req1_op,
  input  logic [4:0]  req0_addr,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req0_wdata,
  input  logic [31:0] req1_wdata,
  output logic [31:0] arr_q,
  output logic        wr_done,
  output logic        wr_id,
  output logic [7:0]  wr_cnt
);
  typedef enum logic {IDLE, COMMIT} state_t;
  state_t      state, state_n;
  logic        rr_ptr, grant, accept;
  logic [1:0]  stg_op;
  logic [4:0]  stg_addr, sh;
  logic [31:0] stg_wdata, wmask, arr_n;
  logic        stg_id;
  // grant selection, handshake strobes and next state
  always_comb begin
    grant     = (&req_valid) ? rr_ptr : req_valid[1];
    accept    = state == IDLE && !clr && |req_valid;
    req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
    wr_done   = state == COMMIT && !clr;
    wr_id     = stg_id;
    state_n   = accept ? COMMIT : IDLE;
  end
  // field placement: a field of width w sits at a w-aligned offset taken from addr
  always_comb begin
    sh    = stg_op == 2'd0 ? stg_addr : stg_op == 2'd1 ? {stg_addr[4:3], 3'b000} :
            stg_op == 2'd2 ? {stg_addr[4], 4'b0000} : 5'd0;
    wmask = stg_op == 2'd0 ? 32'h0000_0001 : stg_op == 2'd1 ? 32'h0000_00FF :
            stg_op == 2'd2 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    arr_n = (arr_q & ~(wmask << sh)) | ((stg_wdata & wmask) << sh);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // staging captures only the granted requester's payload on accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stg_op    <= '0;
      stg_addr  <= '0;
      stg_wdata <= '0;
      stg_id    <= 1'b0;
    end else if (accept) begin
      stg_op    <= grant ? req1_op : req0_op;
      stg_addr  <= grant ? req1_addr : req0_addr;
      stg_wdata <= grant ? req1_wdata : req0_wdata;
      stg_id    <= grant;
    end
  // array, commit counter and round-robin pointer; clr leaves the pointer alone
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      arr_q  <= RESET_VAL;
      wr_cnt <= '0;
      rr_ptr <= 1'b0;
    end else if (clr) begin
      arr_q  <= RESET_VAL;
      wr_cnt <= '0;
    end else if (wr_done) begin
      arr_q  <= arr_n;
      wr_cnt <= wr_cnt + {7'd0, wr_cnt != 8'hFF};
      rr_ptr <= ~stg_id;
    end
endmodule

// File: tb/tb_packed_reg_arbiter.sv
// tb_packed_reg_arbiter: vector table, hand sequences and random traffic against a reference model
module tb_packed_reg_arbiter;
  localparam logic [31:0] RV = 32'h5A5A_C3C3;
  logic        clk = 0, rst_n = 0, clr = 0;
  logic [1:0]  req_valid = 0, req_ready, req0_op = 0, req1_op = 0;
  logic [4:0]  req0_addr = 0, req1_addr = 0;
  logic [31:0] req0_wdata = 0, req1_wdata = 0, arr_q;
  logic        wr_done, wr_id;
  logic [7:0]  wr_cnt;
  int checks = 0, errors = 0, last_grant;
  bit          m_busy, m_rr, m_id;
  logic [1:0]  m_op;
  logic [4:0]  m_addr;
  logic [31:0] m_wd, m_arr;
  int          m_cnt;

  packed_reg_arbiter #(.RESET_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req1_op(req1_op), .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata), .arr_q(arr_q), .wr_done(wr_done),
    .wr_id(wr_id), .wr_cnt(wr_cnt));

  always #5 clk = ~clk;

  typedef struct {
    bit          id;
    logic [1:0]  op;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] put_field(logic [31:0] a, logic [1:0] op, logic [4:0] ad, logic [31:0] wd);
    int w, base;
    w    = op == 0 ? 1 : op == 1 ? 8 : op == 2 ? 16 : 32;
    base = op == 0 ? int'(ad) : op == 1 ? (int'(ad) / 8) * 8 : op == 2 ? (int'(ad) / 16) * 16 : 0;
    for (int i = 0; i < w; i++) a[base + i] = wd[i];
    return a;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_rr = 0; m_id = 0; m_arr = RV; m_cnt = 0;
  endtask

  task automatic cycle();
    logic [1:0] er;
    int g;
    er = 0; g = -1;
    #1;
    if (!m_busy && !clr && req_valid != 0) begin
      g = req_valid == 2'b11 ? int'(m_rr) : int'(req_valid[1]);
      er[g] = 1'b1;
    end
    chk("ready", 32'(req_ready), 32'(er));
    chk("done", 32'(wr_done), 32'(m_busy && !clr));
    if (m_busy && !clr) chk("id", 32'(wr_id), 32'(m_id));
    chk("arr", arr_q, m_arr);
    chk("cnt", 32'(wr_cnt), 32'(m_cnt));
    last_grant = g;
    @(posedge clk);
    if (clr) begin
      m_arr = RV; m_cnt = 0; m_busy = 0;
    end else if (m_busy) begin
      m_arr = put_field(m_arr, m_op, m_addr, m_wd);
      if (m_cnt < 255) m_cnt++;
      m_rr = !m_id;
      m_busy = 0;
    end else if (g >= 0) begin
      m_busy = 1; m_id = g[0];
      m_op   = g == 1 ? req1_op : req0_op;
      m_addr = g == 1 ? req1_addr : req0_addr;
      m_wd   = g == 1 ? req1_wdata : req0_wdata;
    end
    @(negedge clk);
  endtask

  task automatic drive(bit id, logic [1:0] op, logic [4:0] ad, logic [31:0] wd);
    if (id) begin req1_op = op; req1_addr = ad; req1_wdata = wd; end
    else begin req0_op = op; req0_addr = ad; req0_wdata = wd; end
  endtask

  initial begin
    int exp_g[8];
    bit granted;
    vecs[0] = '{0, 2'd3, 5'h00, 32'h0123_4567, 32'h0123_4567};
    vecs[1] = '{1, 2'd1, 5'h18, 32'h0000_00AB, 32'hAB23_4567};
    vecs[2] = '{0, 2'd2, 5'h00, 32'h0000_BEEF, 32'hAB23_BEEF};
    vecs[3] = '{1, 2'd0, 5'h00, 32'h0000_0000, 32'hAB23_BEEE};
    vecs[4] = '{0, 2'd0, 5'h1F, 32'h0000_0000, 32'h2B23_BEEE};
    vecs[5] = '{1, 2'd1, 5'h08, 32'hFFFF_FF00, 32'h2B23_00EE};
    vecs[6] = '{0, 2'd2, 5'h10, 32'h1234_5678, 32'h5678_00EE};
    vecs[7] = '{1, 2'd1, 5'h10, 32'h0000_0099, 32'h5699_00EE};
    vecs[8] = '{0, 2'd3, 5'h1F, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    exp_g = '{0, -1, 1, -1, 0, -1, 1, -1};
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_arr", arr_q, RV);
    chk("reset_cnt", 32'(wr_cnt), 0);
    chk("reset_done", 32'(wr_done), 0);
    chk("reset_ready", 32'(req_ready), 0);
    rst_n = 1;
    @(negedge clk);
    // contention from reset: grants alternate every two cycles
    drive(0, 2'd3, 0, 32'h1111_1111);
    drive(1, 2'd3, 0, 32'h2222_2222);
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("contention_grant", 32'(last_grant), 32'(exp_g[k]));
    end
    req_valid = 0;
    cycle();
    // table of single-requester writes
    foreach (vecs[i]) begin
      drive(vecs[i].id, vecs[i].op, vecs[i].addr, vecs[i].wd);
      req_valid = vecs[i].id ? 2'b10 : 2'b01;
      cycle();
      chk("tbl_grant", 32'(last_grant), 32'(vecs[i].id));
      req_valid = 0;
      cycle();
      chk("tbl_arr", arr_q, vecs[i].exp);
    end
    cycle();
    // clear during commit drops the staged write
    drive(0, 2'd3, 0, 32'hFFFF_FFFF);
    req_valid = 2'b01;
    cycle();
    req_valid = 0;
    clr = 1;
    cycle();
    clr = 0;
    #1;
    chk("clr_arr", arr_q, RV);
    chk("clr_cnt", 32'(wr_cnt), 0);
    chk("clr_done", 32'(wr_done), 0);
    req_valid = 2'b01;
    #1;
    chk("clr_idle_ready", 32'(req_ready), 1);
    cycle();
    req_valid = 0;
    cycle();
    // asynchronous reset inside a commit
    drive(1, 2'd3, 0, 32'h0F0F_0F0F);
    req_valid = 2'b10;
    cycle();
    req_valid = 0;
    #1 rst_n = 0;
    #1;
    chk("async_arr", arr_q, RV);
    chk("async_done", 32'(wr_done), 0);
    chk("async_cnt", 32'(wr_cnt), 0);
    chk("async_ready", 32'(req_ready), 0);
    #1 rst_n = 1;
    model_reset();
    @(negedge clk);
    cycle();
    cycle();
    // random traffic; a waiting requester holds its payload until accepted
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 2; r++) begin
        granted = last_grant == r;
        if (!req_valid[r] || granted) begin
          req_valid[r] = $urandom_range(0, 2) != 0;
          drive(r[0], 2'($urandom), 5'($urandom), $urandom);
        end
      end
      clr = $urandom_range(0, 19) == 0;
      cycle();
    end
    clr = 0;
    req_valid = 0;
    cycle();
    cycle();
    // saturation of the commit counter
    req_valid = 2'b01;
    for (int n = 0; n < 260; n++) begin
      drive(0, 2'd3, 0, $urandom);
      cycle();
      cycle();
    end
    req_valid = 0;
    cycle();
    chk("sat_cnt", 32'(wr_cnt), 32'hFF);
    clr = 1;
    cycle();
    clr = 0;
    #1;
    chk("sat_clr_cnt", 32'(wr_cnt), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
